// File: rtl/cru_pkg.sv
// Shared constants and types for the clock/reset unit: default divide ratios,
// counter width and the system clock rate used by benches.
package cru_pkg;

  localparam int  CNT_W_DEFAULT = 16;
  localparam int  MAX_EN        = 8;
  localparam int  DIV_960K      = 250;
  localparam int  DIV_32K       = 30;
  localparam real CLK_HZ        = 240.0e6;

  typedef int div_arr_t [MAX_EN];

  // A ratio is legal when its terminal count DIV-1 fits in cnt_w bits.
  function automatic logic div_ok(input int div, input int cnt_w);
    return (div >= 1) && (longint'(div) <= (longint'(1) << cnt_w));
  endfunction

endpackage

// File: rtl/cru_div_stage.sv
// One divider channel: counts ticks and flags the tick that completes a period.
// The counter wraps to zero on its own terminal count, so it can never overflow.
module cru_div_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] div_last_i,
  output logic             term_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign term_o = tick_i && (cnt_q == div_last_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || term_o) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cru_gen.sv
// Clock/reset unit: synchronises the power-on reset and derives NUM_EN cascaded,
// phase-aligned single-cycle enables from clk240m, plus a sticky ready flag.
module cru_gen
  import cru_pkg::*;
#(
  parameter int NUM_EN           = 2,
  parameter int CNT_W            = CNT_W_DEFAULT,
  parameter int DIV [NUM_EN]     = '{DIV_960K, DIV_32K},
  parameter int SYNC_STAGES      = 2
) (
  input  logic              clk240m,
  input  logic              reset_in_n,
  output logic              reset_out,
  input  logic              resync,
  output logic [NUM_EN-1:0] en,
  output logic              ready
);

  if (NUM_EN < 1 || NUM_EN > MAX_EN) begin : g_bad_num_en
    $error("cru_gen: NUM_EN=%0d outside 1..%0d", NUM_EN, MAX_EN);
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("cru_gen: SYNC_STAGES=%0d must be at least 2", SYNC_STAGES);
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic [NUM_EN-1:0]      term;
  logic [NUM_EN-1:0]      en_q, en_d;
  logic                   ready_q, ready_d;
  logic                   resync_eff;
  logic                   run;
  logic                   clear;

  // Reset asserts immediately and releases only after SYNC_STAGES clean edges.
  always_ff @(posedge clk240m or negedge reset_in_n) begin
    if (!reset_in_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign reset_out  = ~sync_q[SYNC_STAGES-1];
  assign resync_eff = resync & ~reset_out;
  assign run        = ~reset_out & ~resync_eff;
  assign clear      = reset_out | resync_eff;

  // Each channel ticks on the terminal count of the one before it, so all
  // enables coincide with the fastest one.
  for (genvar g = 0; g < NUM_EN; g++) begin : g_stage
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV[g] - 1);
    logic tick_g;
    logic term_g;

    if (!div_ok(DIV[g], CNT_W)) begin : g_bad_div
      $error("cru_gen: DIV[%0d]=%0d outside 1..2**CNT_W", g, DIV[g]);
    end

    if (g == 0) begin : g_first
      assign tick_g = run;
    end else begin : g_next
      assign tick_g = g_stage[g-1].term_g;
    end

    cru_div_stage #(
      .CNT_W (CNT_W)
    ) u_stage (
      .clk_i      (clk240m),
      .rst_ni     (reset_in_n),
      .tick_i     (tick_g),
      .clear_i    (clear),
      .div_last_i (LAST),
      .term_o     (term_g)
    );

    assign term[g] = term_g;
  end

  always_comb begin
    en_d    = term;
    ready_d = ready_q | term[NUM_EN-1];
    if (clear) begin
      en_d    = '0;
      ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk240m or negedge reset_in_n) begin
    if (!reset_in_n) begin
      en_q    <= '0;
      ready_q <= 1'b0;
    end else begin
      en_q    <= en_d;
      ready_q <= ready_d;
    end
  end

  assign en    = en_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_cru_gen.sv
// Directed bench for cru_gen: default 960k/32k instance plus a 3-channel
// instance with a bypassed middle stage and a deeper reset synchroniser.
`timescale 1ns/1ps
module tb_cru_gen;
  import cru_pkg::*;

  localparam real HALF_NS = 1.0e9 / CLK_HZ / 2.0;
  localparam int  DIV_B [3] = '{4, 1, 3};

  logic       clk240m = 1'b0;
  logic       rstA_n, resyncA, rstB_n, resyncB;
  logic       resetOutA, readyA, resetOutB, readyB;
  logic [1:0] enA;
  logic [2:0] enB;

  int vecCount = 0;
  int missCount = 0;

  int rA, rB, errA, errB, errAlign, errR;
  logic expEn0, expEn1, expRdy, rs;
  logic [2:0] expB;

  always #(HALF_NS) clk240m = ~clk240m;

  cru_gen dutA (
    .clk240m    (clk240m),
    .reset_in_n (rstA_n),
    .reset_out  (resetOutA),
    .resync     (resyncA),
    .en         (enA),
    .ready      (readyA)
  );

  cru_gen #(
    .NUM_EN      (3),
    .DIV         (DIV_B),
    .SYNC_STAGES (3)
  ) dutB (
    .clk240m    (clk240m),
    .reset_in_n (rstB_n),
    .reset_out  (resetOutB),
    .resync     (resyncB),
    .en         (enB),
    .ready      (readyB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive resync for the current cycle, then move to the sample point of the next.
  task automatic applyStimulus(input logic resyncVal);
    resyncA = resyncVal;
    @(posedge clk240m);
    #1;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstA_n = 1'b0; rstB_n = 1'b0; resyncA = 1'b0; resyncB = 1'b0;
    errA = 0; errB = 0; errAlign = 0; errR = 0;
    #10;
    checkOutput("A reset reset_out", resetOutA, 1);
    checkOutput("A reset en", enA, 0);
    checkOutput("A reset ready", readyA, 0);
    checkOutput("B reset reset_out", resetOutB, 1);
    checkOutput("B reset en", enB, 0);

    @(posedge clk240m); #1;
    rstA_n = 1'b1; rstB_n = 1'b1;
    applyStimulus(1'b0);
    checkOutput("A reset_out edge1", resetOutA, 1);
    checkOutput("B reset_out edge1", resetOutB, 1);
    applyStimulus(1'b0);
    checkOutput("A reset_out edge2", resetOutA, 0);
    checkOutput("B reset_out edge2", resetOutB, 1);

    // rA is the run-cycle index of dutA; resync restarts it at zero next cycle.
    rA = 0;
    for (int t = 0; t <= 16005; t++) begin
      expEn0 = (rA > 0) && (rA % 250 == 0);
      expEn1 = (rA > 0) && (rA % 7500 == 0);
      expRdy = (rA >= 7500);
      if (enA !== {expEn1, expEn0} || readyA !== expRdy || resetOutA !== 1'b0) errA++;
      if (enA[1] && !enA[0]) errAlign++;
      if (enB[1] !== enB[0] || (enB[2] && !enB[1])) errAlign++;

      if (t >= 1 && t <= 200) begin
        rB = t - 1;
        expB[0] = (rB > 0) && (rB % 4 == 0);
        expB[1] = expB[0];
        expB[2] = (rB > 0) && (rB % 12 == 0);
        if (enB !== expB || readyB !== (rB >= 12) || resetOutB !== 1'b0) errB++;
      end

      case (t)
        1:     checkOutput("B reset_out edge3", resetOutB, 0);
        4:     checkOutput("B en run3", enB, 3'b000);
        5:     checkOutput("B en run4 bypass", enB, 3'b011);
        12:    checkOutput("B ready run11", readyB, 0);
        13: begin
          checkOutput("B en run12", enB, 3'b111);
          checkOutput("B ready run12", readyB, 1);
        end
        249:   checkOutput("A en run249", enA, 2'b00);
        250:   checkOutput("A en run250", enA, 2'b01);
        251:   checkOutput("A en run251", enA, 2'b00);
        500:   checkOutput("A en run500", enA, 2'b01);
        7499:  checkOutput("A ready run7499", readyA, 0);
        7500: begin
          checkOutput("A en run7500", enA, 2'b11);
          checkOutput("A ready run7500", readyA, 1);
        end
        7701: begin
          checkOutput("A en after resync", enA, 2'b00);
          checkOutput("A ready after resync", readyA, 0);
        end
        7951:  checkOutput("A en suppressed by resync", enA, 2'b00);
        8201:  checkOutput("A en 250 after resync", enA, 2'b01);
        8754:  checkOutput("A en held resync 249", enA, 2'b00);
        8755: begin
          checkOutput("A en held resync 250", enA, 2'b01);
          checkOutput("A ready held resync", readyA, 0);
        end
        16005: begin
          checkOutput("A en second cascade", enA, 2'b11);
          checkOutput("A ready second cascade", readyA, 1);
        end
        default: ;
      endcase

      if (t == 16005) break;
      rs = (t == 7700) || (t == 7950) || (t >= 8500 && t <= 8504);
      rA = rs ? 0 : rA + 1;
      applyStimulus(rs);
    end

    checkOutput("A per-cycle errors", errA, 0);
    checkOutput("B per-cycle errors", errB, 0);
    checkOutput("enable alignment errors", errAlign, 0);

    // Pull reset low between edges while en and ready are both high.
    rstA_n = 1'b0; rstB_n = 1'b0;
    #0.5;
    checkOutput("A midreset reset_out", resetOutA, 1);
    checkOutput("A midreset en", enA, 0);
    checkOutput("A midreset ready", readyA, 0);
    checkOutput("B midreset reset_out", resetOutB, 1);
    #2.5;
    rstA_n = 1'b1; rstB_n = 1'b1;
    @(posedge clk240m); #1;
    checkOutput("A restart edge1", resetOutA, 1);
    checkOutput("B restart edge1", resetOutB, 1);
    applyStimulus(1'b0);
    checkOutput("A restart edge2", resetOutA, 0);
    checkOutput("B restart edge2", resetOutB, 1);

    for (int r = 0; r <= 251; r++) begin
      expEn0 = (r > 0) && (r % 250 == 0);
      if (enA !== {1'b0, expEn0} || readyA !== 1'b0 || resetOutA !== 1'b0) errR++;
      if (r == 1) checkOutput("B restart edge3", resetOutB, 0);
      if (r == 249) checkOutput("A restart en run249", enA, 2'b00);
      if (r == 250) checkOutput("A restart en run250", enA, 2'b01);
      applyStimulus(1'b0);
    end
    checkOutput("A restart per-cycle errors", errR, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
